jedro_1_opfetch: RTL
====================

# jedro_1_opfetch

Operand-fetch stage of the jedro_1 pipeline, between instruction fetch/decode and execute. It accepts one instruction per cycle over a valid/ready handshake and drives the two register-file read ports combinationally. It registers the operands into a one-entry output stage. A 32-bit scoreboard of pending writes stalls RAW and WAW hazards, and writeback data is bypassed in the same cycle.

## Interface
- DATA_WIDTH, 32, operand width
- ADDR_WIDTH, 5, register address width (32 registers)
- clk_i  in  1  clock, all state updates on rising edge
- rstn_i  in  1  reset, asynchronous, active-low
- instr_i  in  32  RV32I instruction word
- instr_valid_i  in  1  instr_i valid
- instr_ready_o  out  1  stage accepts instr_i this cycle
- rpb_addr_o  out  ADDR_WIDTH  register-file read port B address = instr_i[19:15] (rs1)
- rpb_data_i  in  DATA_WIDTH  read port B data (combinational)
- rpc_addr_o  out  ADDR_WIDTH  register-file read port C address = instr_i[24:20] (rs2)
- rpc_data_i  in  DATA_WIDTH  read port C data (combinational)
- wb_we_i  in  1  writeback occurring this cycle (same signal as the register-file write enable)
- wb_addr_i  in  ADDR_WIDTH  writeback destination
- wb_data_i  in  DATA_WIDTH  writeback data
- flush_i  in  1  discard the held output entry
- op_valid_o  out  1  output entry valid
- op_ready_i  in  1  execute consumes the entry
- instr_o  out  32  registered instruction
- rs1_data_o, rs2_data_o  out  DATA_WIDTH  registered operands
- rd_addr_o  out  ADDR_WIDTH  registered instr[11:7]
- rd_we_o  out  1  instruction writes rd (rd != 0)
- illegal_o  out  1  opcode not in the supported set

## Operation
- Opcode classes, from instr_i[6:0]:
  - Writes rd: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, LOAD 0000011, OP-IMM 0010011, OP 0110011.
  - Uses rs1: JALR, BRANCH 1100011, LOAD, STORE 0100011, OP-IMM, OP.
  - Uses rs2: BRANCH, STORE, OP.
  - FENCE 0001111 and SYSTEM 1110011 are legal and use no registers.
  - Any other opcode sets illegal_o=1, rd_we=0, and uses no registers.
- Scoreboard: pending[31:1] flip-flops; pending[0] is constant 0.
- "Clearing this cycle": a register r satisfies wb_clr(r) when wb_we_i && wb_addr_i==r.
- hazard = any of the following:
  - rs1 used && pending[rs1] && !wb_clr(rs1);
  - rs2 used && pending[rs2] && !wb_clr(rs2);
  - writes rd && pending[rd] && !wb_clr(rd) (WAW).
- instr_ready_o = (!op_valid_o || op_ready_i) && !hazard && !flush_i.
- Accept: instr_valid_i && instr_ready_o. On accept, the output registers load:
  - instr_i, illegal flag, rd_addr, rd_we;
  - operands chosen per source in this priority: if rs==0 → 0; else if wb_clr(rs) → wb_data_i (bypass); else the port data.
  - Unused operands are still loaded with the same selection.
- op_valid_o:
  - set on accept;
  - cleared on op_ready_i && op_valid_o without an accept;
  - cleared on flush_i.
- Pending update each cycle:
  - clear wb_addr_i if wb_we_i;
  - then set rd if accept && rd_we;
  - set wins on the same index.
- Flush: if op_valid_o && rd_we_o, clear pending[rd_addr_o]. This clear overrides a writeback clear of the same index, which is harmless. No accept happens in that cycle.
- wb_we_i to x0 is ignored.
- rpb_addr_o and rpc_addr_o are driven from instr_i regardless of instr_valid_i.

## Timing
- Reset (async assert, sync release):
  - op_valid_o=0; instr_o, operands, rd_addr_o, rd_we_o, illegal_o = 0;
  - pending = 0;
  - instr_ready_o is 1 after reset when no flush is asserted.
- Latency: accept at edge N → op_valid_o high after edge N. Throughput is 1 per cycle with op_ready_i held high.
- Output holds stable while op_valid_o && !op_ready_i.
- A stalled instruction is accepted in the same cycle its producer's writeback occurs, using the bypassed value. The best-case RAW distance is one writeback.
- Output registers are not reset-gated beyond the reset values above. All pending bits clear immediately on reset assertion.

## Test plan
- Reset release, ADDI x1,x0,5 (0x00500093) valid, op_ready_i=1:
  - instr_ready_o=1;
  - next cycle op_valid_o=1, rd_addr_o=1, rd_we_o=1, rs1_data_o=0;
  - pending[1]=1.
- RAW stall: after the test above, ADD x2,x1,x1 (0x00108133):
  - instr_ready_o=0 until wb_we_i=1, wb_addr_i=1, wb_data_i=5;
  - accepted that cycle with rs1_data_o=rs2_data_o=5 (bypass, port data 0).
- WAW: x3 pending, ADDI x3,x0,1 presented → stalled. Writeback to x3 → accepted, and pending[3]=1 afterward.
- Backpressure: op_ready_i=0 with op_valid_o=1 → instr_ready_o=0 and outputs stable for 3 cycles. op_ready_i=1 → the next instruction is accepted in the same cycle.
- Flush with ADDI x4 held: flush_i=1 → op_valid_o=0, pending[4]=0, no accept that cycle.
- Illegal opcode 0x0000007F → illegal_o=1, rd_we_o=0, no pending bit set. SW x5,0(x6) with x5 pending → stalled until writeback to x5.

Source files
------------

// File: rtl/jedro_1_opfetch_if.sv
// Signal bundle between decode, the register file, writeback and execute for the
// jedro_1 operand-fetch stage. The slave modport is the stage's view.
interface jedro_1_opfetch_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [31:0]           instr_i;
  logic                  instr_valid_i;
  logic                  instr_ready_o;
  logic [ADDR_WIDTH-1:0] rpb_addr_o;
  logic [DATA_WIDTH-1:0] rpb_data_i;
  logic [ADDR_WIDTH-1:0] rpc_addr_o;
  logic [DATA_WIDTH-1:0] rpc_data_i;
  logic                  wb_we_i;
  logic [ADDR_WIDTH-1:0] wb_addr_i;
  logic [DATA_WIDTH-1:0] wb_data_i;
  logic                  flush_i;
  logic                  op_valid_o;
  logic                  op_ready_i;
  logic [31:0]           instr_o;
  logic [DATA_WIDTH-1:0] rs1_data_o;
  logic [DATA_WIDTH-1:0] rs2_data_o;
  logic [ADDR_WIDTH-1:0] rd_addr_o;
  logic                  rd_we_o;
  logic                  illegal_o;

  modport slave (
    input  instr_i, instr_valid_i, rpb_data_i, rpc_data_i,
           wb_we_i, wb_addr_i, wb_data_i, flush_i, op_ready_i,
    output instr_ready_o, rpb_addr_o, rpc_addr_o, op_valid_o,
           instr_o, rs1_data_o, rs2_data_o, rd_addr_o, rd_we_o, illegal_o
  );

  modport master (
    output instr_i, instr_valid_i, rpb_data_i, rpc_data_i,
           wb_we_i, wb_addr_i, wb_data_i, flush_i, op_ready_i,
    input  instr_ready_o, rpb_addr_o, rpc_addr_o, op_valid_o,
           instr_o, rs1_data_o, rs2_data_o, rd_addr_o, rd_we_o, illegal_o
  );
endinterface

// File: rtl/jedro_1_opfetch.sv
// jedro_1 operand-fetch stage: decodes register usage, stalls on RAW/WAW against a
// pending-write scoreboard, bypasses same-cycle writeback and registers one entry.
module jedro_1_opfetch #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input logic                clk_i,
  input logic                rstn_i,
  jedro_1_opfetch_if.slave   bus
);

  localparam int NREGS = 2 ** ADDR_WIDTH;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  logic [ADDR_WIDTH-1:0] rs1, rs2, rd;
  logic                  writes_rd, use_rs1, use_rs2, illegal, rd_we;
  logic                  hazard, ready, accept;

  logic                  op_valid_q, op_valid_d;
  logic [31:0]           instr_q;
  logic [DATA_WIDTH-1:0] rs1_q, rs2_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic                  rd_we_q, illegal_q;

  logic [NREGS-1:1]      pending_q, pending_d;
  logic [NREGS-1:0]      pending;
  logic [NREGS-1:0]      pend_nxt;

  assign rs1     = bus.instr_i[19:15];
  assign rs2     = bus.instr_i[24:20];
  assign rd      = bus.instr_i[11:7];
  assign pending = {pending_q, 1'b0};

  function automatic logic wb_clr(input logic [ADDR_WIDTH-1:0] r);
    return bus.wb_we_i && (bus.wb_addr_i == r) && (r != '0);
  endfunction

  // x0 reads as zero even if something writes back to it; bypass beats the port.
  function automatic logic [DATA_WIDTH-1:0] sel_operand(input logic [ADDR_WIDTH-1:0] r,
                                                        input logic [DATA_WIDTH-1:0] port);
    if (r == '0)     return '0;
    else if (wb_clr(r)) return bus.wb_data_i;
    else             return port;
  endfunction

  always_comb begin
    writes_rd = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    illegal   = 1'b0;
    unique case (bus.instr_i[6:0])
      OPC_LUI, OPC_AUIPC, OPC_JAL: writes_rd = 1'b1;
      OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
        writes_rd = 1'b1;
        use_rs1   = 1'b1;
      end
      OPC_OP: begin
        writes_rd = 1'b1;
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
      end
      OPC_BRANCH, OPC_STORE: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OPC_FENCE, OPC_SYSTEM: ;
      default: illegal = 1'b1;
    endcase
  end

  assign rd_we  = writes_rd && (rd != '0);
  assign hazard = (use_rs1   && pending[rs1] && !wb_clr(rs1)) ||
                  (use_rs2   && pending[rs2] && !wb_clr(rs2)) ||
                  (writes_rd && pending[rd]  && !wb_clr(rd));
  assign ready  = (!op_valid_q || bus.op_ready_i) && !hazard && !bus.flush_i;
  assign accept = bus.instr_valid_i && ready;

  always_comb begin
    op_valid_d = op_valid_q;
    if (bus.flush_i)                        op_valid_d = 1'b0;
    else if (accept)                        op_valid_d = 1'b1;
    else if (bus.op_ready_i && op_valid_q)  op_valid_d = 1'b0;
  end

  // Writeback clear first, then the new destination, so a set on the same index wins.
  always_comb begin
    pend_nxt = pending;
    if (bus.wb_we_i) pend_nxt[bus.wb_addr_i] = 1'b0;
    if (accept && rd_we) pend_nxt[rd] = 1'b1;
    if (bus.flush_i && op_valid_q && rd_we_q) pend_nxt[rd_addr_q] = 1'b0;
    pend_nxt[0] = 1'b0;
    pending_d   = pend_nxt[NREGS-1:1];
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      op_valid_q <= 1'b0;
      instr_q    <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_addr_q  <= '0;
      rd_we_q    <= 1'b0;
      illegal_q  <= 1'b0;
      pending_q  <= '0;
    end else begin
      op_valid_q <= op_valid_d;
      pending_q  <= pending_d;
      if (accept) begin
        instr_q   <= bus.instr_i;
        rs1_q     <= sel_operand(rs1, bus.rpb_data_i);
        rs2_q     <= sel_operand(rs2, bus.rpc_data_i);
        rd_addr_q <= rd;
        rd_we_q   <= rd_we;
        illegal_q <= illegal;
      end
    end
  end

  assign bus.instr_ready_o = ready;
  assign bus.rpb_addr_o    = rs1;
  assign bus.rpc_addr_o    = rs2;
  assign bus.op_valid_o    = op_valid_q;
  assign bus.instr_o       = instr_q;
  assign bus.rs1_data_o    = rs1_q;
  assign bus.rs2_data_o    = rs2_q;
  assign bus.rd_addr_o     = rd_addr_q;
  assign bus.rd_we_o       = rd_we_q;
  assign bus.illegal_o     = illegal_q;

endmodule
